uart_frame_parser: RTL
======================

// Module: uart_frame_parser
// PURPOSE
//  Sits between uart_rx and the P10 display controller. Accepts the byte stream
//  (rx_data/rx_data_valid) and frames it as [SOF][PAYLOAD_LEN bytes][XOR checksum].
//  Payload bytes go out as a write stream into the display staging buffer.
//  frame_commit pulses only after a complete frame with a correct checksum, which
//  tells the display to adopt the staged data. Corrupt or stalled frames are reported
//  and never committed.
// PARAMETERS
//  PAYLOAD_LEN  64        payload bytes per frame (one full 4-row x 16-byte P10 image)
//  ADDR_W       6         wr_addr width; PAYLOAD_LEN <= 2**ADDR_W
//  SOF_BYTE     8'hA5     start-of-frame marker
//  TIMEOUT_CYC  2000000   max clk cycles allowed between bytes inside a frame
// PORTS
//  clk            in   1        system clock (27 MHz)
//  rst            in   1        asynchronous reset, active-low
//  rx_data        in   8        byte from uart_rx
//  rx_data_valid  in   1        byte valid; one beat = one byte
//  rx_data_ready  out  1        parser can accept a byte
//  wr_en          out  1        staging-buffer write strobe
//  wr_addr        out  ADDR_W   payload byte index, 0..PAYLOAD_LEN-1
//  wr_data        out  8        payload byte
//  frame_commit   out  1        1-cycle pulse: staged frame is valid
//  frame_error    out  1        1-cycle pulse: frame discarded
//  err_code       out  2        01 checksum mismatch, 10 timeout; holds until next error
//  busy           out  1        high while the FSM is not in IDLE
//  ack_data       out  8        ACK/NAK byte for uart_tx (FRAME_ACK_EN only)
//  ack_valid      out  1        ack_data valid (FRAME_ACK_EN only)
//  ack_ready      in   1        uart_tx accepted ack_data (FRAME_ACK_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except rx_data_ready=1. Counters and checksum = 0.
//  Beat = rx_data_valid & rx_data_ready, sampled on posedge clk.
//  FSM:
//  - IDLE:    beat with rx_data==SOF_BYTE -> PAYLOAD, idx=0, csum=0.
//             Any other byte is dropped silently (no error pulse).
//  - PAYLOAD: each beat -> wr_en=1, wr_addr=idx, wr_data=byte, registered 1 cycle
//             after the beat; csum ^= byte; idx++.
//             Beat with idx==PAYLOAD_LEN-1 -> CHECK. A SOF-valued byte here is data.
//  - CHECK:   next beat is the checksum byte.
//             Equal to csum -> frame_commit=1 the following cycle.
//             Not equal -> frame_error=1 and err_code=01 the following cycle.
//             Either way -> IDLE.
//  Timeout: the cycle counter clears on every beat and counts while not in IDLE.
//   Reaching TIMEOUT_CYC-1 -> frame_error=1, err_code=10, state -> IDLE, no commit.
//   A beat in the same cycle as expiry wins: the counter clears and the byte is
//   processed normally.
//  Already-written staging bytes are not rolled back; downstream uses only committed data.
//  Width rules: idx saturates at PAYLOAD_LEN-1; csum is 8-bit XOR; counter is
//   $clog2(TIMEOUT_CYC) bits.
//  Reset mid-frame: returns to IDLE with no commit/error pulse; the next frame needs
//   a fresh SOF.
//  Throughput: one byte per clk is sustained; 1-cycle latency from beat to wr_en /
//   commit / error.
// CONFIGURATION
//  FRAME_ACK_EN defined:
//  - Every commit loads ack_data=8'h06; every error loads ack_data=8'h15; ack_valid=1.
//  - ack_valid stays high until ack_ready; ack_data is stable while ack_valid=1.
//  - rx_data_ready = !(ack_valid & !ack_ready).
//  - A new commit/error while an ACK is pending overwrites ack_data (latest status wins).
//  FRAME_ACK_EN undefined: ack_data=0 and ack_valid=0 constantly; ack_ready ignored;
//   rx_data_ready=1.
// STRUCTURE
//  uart_frame_pkg: FSM state encoding (IDLE/PAYLOAD/CHECK), ERR_CSUM=2'b01,
//   ERR_TIMEOUT=2'b10, ACK_BYTE=8'h06, NAK_BYTE=8'h15, default SOF_BYTE.
//  Sub-module frame_timeout: parameterised down-counter with inputs clear/enable and
//   output expire pulse. It can be reused by the display controller's receive timeout.
// TESTING
//  1. Byte 0xA5, payload 0x00..0x3F, checksum 0x00 -> 64 writes addr 0..63 with
//     data==addr; frame_commit once; no error.
//  2. Same frame with checksum 0x01 -> 64 writes; frame_error=1; err_code=01;
//     no frame_commit.
//  3. SOF then 10 bytes, then idle for TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=100)
//     -> frame_error at cycle 100 after the last beat; err_code=10; busy=0.
//  4. Garbage 0x11,0x22, then a valid frame whose payload contains 0xA5 -> garbage
//     ignored; 0xA5 written as data; commit.
//  5. Assert rst low after 30 payload bytes, release, send a valid frame
//     -> no pulse during reset; second frame commits; wr_addr restarts at 0.
//  6. FRAME_ACK_EN, ack_ready held low after a good frame -> ack_valid=1,
//     ack_data=0x06, rx_data_ready=0 until ack_ready=1.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser and its helpers.
package uart_frame_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } frame_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [7:0] ACK_BYTE    = 8'h06;
   localparam logic [7:0] NAK_BYTE    = 8'h15;
   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and flags
// expiry TIMEOUT_CYC-1 enabled cycles after the last clear. Clear beats expiry.
module frame_timeout #(
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= LOAD_VAL;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = enable && !clear && (cnt == '0);

endmodule

// File: rtl/uart_frame_parser.sv
// Frames the uart_rx byte stream as [SOF][payload][XOR checksum] and streams
// payload into the display staging buffer. Optional ACK/NAK path: FRAME_ACK_EN.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int unsigned PAYLOAD_LEN = 64,
   parameter int unsigned ADDR_W      = 6,
   parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_data_valid,
   output logic              rx_data_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              frame_commit,
   output logic              frame_error,
   output logic [1:0]        err_code,
   output logic              busy,
   output logic [7:0]        ack_data,
   output logic              ack_valid,
   input  logic              ack_ready
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PAYLOAD_LEN - 1);

   frame_state_t      state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic [7:0]        csum, csum_nxt;
   logic              beat;
   logic              expire;

   logic              wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [7:0]        wr_data_nxt;
   logic              commit_nxt;
   logic              error_nxt;
   logic [1:0]        err_code_nxt;

   assign beat = rx_data_valid && rx_data_ready;
   assign busy = (state != IDLE);

   frame_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clear (beat),
      .enable(busy),
      .expire(expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
         csum  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         csum  <= csum_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      csum_nxt     = csum;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      commit_nxt   = 1'b0;
      error_nxt    = 1'b0;
      err_code_nxt = err_code;
      case (state)
         IDLE: begin
            if (beat && (rx_data == SOF_BYTE)) begin
               state_nxt = PAYLOAD;
               idx_nxt   = '0;
               csum_nxt  = '0;
            end
         end
         PAYLOAD: begin
            if (beat) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = idx;
               wr_data_nxt = rx_data;
               csum_nxt    = csum ^ rx_data;
               if (idx == LAST_IDX) begin
                  state_nxt = CHECK;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else if (expire) begin
               state_nxt    = IDLE;
               error_nxt    = 1'b1;
               err_code_nxt = ERR_TIMEOUT;
            end
         end
         CHECK: begin
            if (beat) begin
               state_nxt = IDLE;
               if (rx_data == csum) begin
                  commit_nxt = 1'b1;
               end else begin
                  error_nxt    = 1'b1;
                  err_code_nxt = ERR_CSUM;
               end
            end else if (expire) begin
               state_nxt    = IDLE;
               error_nxt    = 1'b1;
               err_code_nxt = ERR_TIMEOUT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         frame_commit <= 1'b0;
         frame_error  <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         wr_en        <= wr_en_nxt;
         wr_addr      <= wr_addr_nxt;
         wr_data      <= wr_data_nxt;
         frame_commit <= commit_nxt;
         frame_error  <= error_nxt;
         err_code     <= err_code_nxt;
      end
   end

`ifdef FRAME_ACK_EN
   // A fresh status overwrites a pending one so uart_tx always reports the latest frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_valid <= 1'b0;
         ack_data  <= '0;
      end else if (commit_nxt || error_nxt) begin
         ack_valid <= 1'b1;
         ack_data  <= commit_nxt ? ACK_BYTE : NAK_BYTE;
      end else if (ack_ready) begin
         ack_valid <= 1'b0;
      end
   end

   assign rx_data_ready = !(ack_valid && !ack_ready);
`else
   logic ack_ready_unused;

   assign ack_ready_unused = ack_ready;
   assign ack_data         = '0;
   assign ack_valid        = 1'b0;
   assign rx_data_ready    = 1'b1;
`endif

endmodule
